// File: rtl/rv_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect input
// and the decoupled valid/ready delivery channel toward decode.
interface rv_fetch_unit_if #(
    parameter int XLEN = 64
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;

    modport master (
        output imem_req_valid, imem_addr, out_valid, out_pc, out_instr,
        input  imem_req_ready, imem_resp_valid, imem_rdata,
               redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, out_valid, out_pc, out_instr,
        output imem_req_ready, imem_resp_valid, imem_rdata,
               redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/rv_fetch_unit.sv
// Instruction-fetch front end: PC, in-order pipelined imem requests, prefetch
// buffer toward decode, and redirect with discard of stale in-flight responses.
module rv_fetch_unit #(
    parameter int          XLEN     = 64,
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    rv_fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [XLEN-1:0] BOOT_PC = {RESET_PC[XLEN-1:2], 2'b00};

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] buf_pc    [DEPTH];
    logic [31:0]     buf_instr [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_next;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard_cnt;
    logic [CW-1:0]   live;
    logic [CW-1:0]   count_after_pop;
    logic [CW:0]     in_use;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] out_pc_q;
    logic [31:0]     out_instr_q;
    logic [XLEN-1:0] head_pc_next;
    logic [31:0]     head_instr_next;
    logic [XLEN-1:0] redirect_aligned;

    assign live             = outstanding - discard_cnt;
    assign in_use           = {1'b0, count} + {1'b0, live};
    assign redirect_aligned = {bus.redirect_pc[XLEN-1:2], 2'b00};

    // Only requests whose responses will be kept reserve buffer space.
    assign bus.imem_req_valid = !reset && !bus.redirect_valid
                              && (in_use < (CW+1)'(DEPTH))
                              && (outstanding < CW'(DEPTH));
    assign bus.imem_addr = fetch_pc;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign push     = bus.imem_resp_valid && !bus.redirect_valid && (discard_cnt == '0);
    assign pop      = (count != '0) && bus.out_ready && !bus.redirect_valid;

    assign rd_next         = rd_ptr + AW'(pop);
    assign count_after_pop = count - CW'(pop);

    assign bus.out_valid = (count != '0);
    assign bus.out_pc    = out_pc_q;
    assign bus.out_instr = out_instr_q;

    // Next head value; an incoming word becomes the head directly when nothing else remains.
    always_comb begin
        head_pc_next    = '0;
        head_instr_next = '0;
        if (!bus.redirect_valid) begin
            if (count_after_pop != '0) begin
                head_pc_next    = buf_pc[rd_next];
                head_instr_next = buf_instr[rd_next];
            end else if (push) begin
                head_pc_next    = resp_pc;
                head_instr_next = bus.imem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]    <= resp_pc;
            buf_instr[wr_ptr] <= bus.imem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= BOOT_PC;
            resp_pc     <= BOOT_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard_cnt <= '0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_resp_valid);
            out_pc_q    <= head_pc_next;
            out_instr_q <= head_instr_next;
            if (bus.redirect_valid) begin
                fetch_pc    <= redirect_aligned;
                resp_pc     <= redirect_aligned;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count       <= '0;
                discard_cnt <= outstanding - CW'(bus.imem_resp_valid);
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + XLEN'(4);
                if (bus.imem_resp_valid && (discard_cnt != '0))
                    discard_cnt <= discard_cnt - CW'(1);
                if (push) begin
                    wr_ptr  <= wr_ptr + AW'(1);
                    resp_pc <= resp_pc + XLEN'(4);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // The issue rule reserves space for every kept response.
    assert property (@(posedge clk) disable iff (reset)
        !(push && (count == CW'(DEPTH)) && !pop));

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Randomized bench for rv_fetch_unit: in-order memory model with random latency
// plus a queue-based reference of the expected instruction stream.
module tb_rv_fetch_unit;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [XLEN-1:0] BOOT = 32'h0000_1000;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        int              due;
        bit              wanted;
    } req_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } ent_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rv_fetch_unit_if #(.XLEN(XLEN)) bus ();

    rv_fetch_unit #(
        .XLEN    (XLEN),
        .RESET_PC(64'h1000),
        .DEPTH   (DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    req_t            mem_q[$];
    ent_t            fifo[$];
    logic [XLEN-1:0] hs_log[$];
    logic [XLEN-1:0] exp_fetch = BOOT;
    int              cyc = 0;
    int              last_due = 0;
    int              n_checks = 0;
    int              n_pass = 0;
    int              lat_min = 1;
    int              lat_max = 1;
    int              ready_mode = 0;   // 0 always, 1 toggle
    int              oready_mode = 0;  // 0 always, 1 never, 2 random
    logic            last_out_valid = 1'b0;
    logic [XLEN-1:0] last_out_pc = '0;
    logic            last_req_valid = 1'b0;

    function automatic logic [31:0] word_of(input logic [XLEN-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step(input bit redir, input logic [XLEN-1:0] tgt);
        bit   resp;
        bit   hs;
        bit   pop;
        bit   exp_req;
        int   live;
        int   d;
        req_t r;
        ent_t e;
        @(negedge clk);
        bus.redirect_valid  = redir;
        bus.redirect_pc     = tgt;
        bus.imem_req_ready  = (ready_mode == 0) ? 1'b1 : 1'(cyc % 2);
        bus.out_ready       = (oready_mode == 0) ? 1'b1 :
                              (oready_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        resp                = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        bus.imem_resp_valid = resp;
        bus.imem_rdata      = resp ? word_of(mem_q[0].addr) : $urandom;
        #1;
        live = 0;
        foreach (mem_q[i]) if (mem_q[i].wanted) live++;
        exp_req = !redir && ((fifo.size() + live) < DEPTH) && (mem_q.size() < DEPTH);
        check_val("imem_req_valid", 64'(bus.imem_req_valid), 64'(exp_req));
        check_val("out_valid", 64'(bus.out_valid), 64'(fifo.size() != 0));
        check_val("out_pc", 64'(bus.out_pc), (fifo.size() != 0) ? 64'(fifo[0].pc) : 64'd0);
        check_val("out_instr", 64'(bus.out_instr), (fifo.size() != 0) ? 64'(fifo[0].instr) : 64'd0);
        last_out_valid = bus.out_valid;
        last_out_pc    = bus.out_pc;
        last_req_valid = bus.imem_req_valid;
        hs = bus.imem_req_valid && bus.imem_req_ready;
        if (hs) begin
            check_val("imem_addr", 64'(bus.imem_addr), 64'(exp_fetch));
            hs_log.push_back(bus.imem_addr);
            exp_fetch = exp_fetch + XLEN'(4);
        end
        pop = (fifo.size() != 0) && bus.out_ready && !redir;
        if (pop) e = fifo.pop_front();
        if (resp) begin
            r = mem_q.pop_front();
            if (r.wanted && !redir) begin
                e.pc    = r.addr;
                e.instr = word_of(r.addr);
                fifo.push_back(e);
            end
        end
        if (redir) begin
            fifo.delete();
            foreach (mem_q[i]) mem_q[i].wanted = 1'b0;
            exp_fetch = tgt & ~XLEN'(3);
        end
        if (hs) begin
            d = cyc + $urandom_range(lat_min, lat_max);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            r.addr   = bus.imem_addr;
            r.due    = d;
            r.wanted = !redir;
            mem_q.push_back(r);
        end
        check_val("outstanding_cap", 64'(mem_q.size() <= DEPTH), 64'd1);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset               = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_rdata      = '0;
        bus.out_ready       = 1'b0;
        #1;
        check_val("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_out_pc", 64'(bus.out_pc), 64'd0);
        check_val("rst_out_instr", 64'(bus.out_instr), 64'd0);
        check_val("rst_imem_addr", 64'(bus.imem_addr), 64'(BOOT));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mem_q.delete();
        fifo.delete();
        hs_log.delete();
        exp_fetch = BOOT;
        last_due  = 0;
    endtask

    task automatic wait_out(input string tag, input logic [XLEN-1:0] exp_pc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(1'b0, '0);
            seen = last_out_valid;
        end
        check_val({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen) check_val(tag, 64'(last_out_pc), 64'(exp_pc));
    endtask

    initial begin
        bit hit;

        // Streaming from reset with a single-cycle memory.
        do_reset();
        lat_min = 1; lat_max = 1; ready_mode = 0; oready_mode = 0;
        step(1'b0, '0);
        step(1'b0, '0);
        check_val("startup_empty", 64'(last_out_valid), 64'd0);
        step(1'b0, '0);
        check_val("startup_valid", 64'(last_out_valid), 64'd1);
        check_val("startup_pc", 64'(last_out_pc), 64'h1000);
        repeat (20) step(1'b0, '0);
        check_val("first_req", 64'(hs_log[0]), 64'h1000);

        // Decode stalled: buffer fills and fetch stops.
        do_reset();
        lat_min = 3; lat_max = 3; oready_mode = 1;
        repeat (15) step(1'b0, '0);
        check_val("stall_req_count", 64'(hs_log.size()), 64'd4);
        check_val("stall_req_valid", 64'(last_req_valid), 64'd0);
        check_val("stall_out_valid", 64'(last_out_valid), 64'd1);
        check_val("stall_out_pc", 64'(last_out_pc), 64'h1000);
        oready_mode = 0;
        repeat (20) step(1'b0, '0);
        check_val("resume_addr", (hs_log.size() > 4) ? 64'(hs_log[4]) : 64'hDEAD, 64'h1010);

        // Redirect with three requests in flight.
        do_reset();
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (mem_q.size() == 3) begin
                step(1'b1, 32'h2002);
                hit = 1'b1;
            end else step(1'b0, '0);
        end
        check_val("redir3_reached", 64'(hit), 64'd1);
        wait_out("redir3_pc", 32'h2000);
        repeat (10) step(1'b0, '0);

        // Redirect coinciding with a response and a pop, then back-to-back redirects.
        do_reset();
        lat_min = 2; lat_max = 4;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (mem_q.size() >= 2 && mem_q[0].due <= cyc && fifo.size() != 0) begin
                step(1'b1, 32'h3000);
                hit = 1'b1;
            end else step(1'b0, '0);
        end
        check_val("redir_resp_pop_reached", 64'(hit), 64'd1);
        wait_out("redir_resp_pop_pc", 32'h3000);
        step(1'b1, 32'h5000);
        step(1'b1, 32'h6007);
        wait_out("b2b_redir_pc", 32'h6004);
        repeat (10) step(1'b0, '0);

        // Address wrap at the top of the 32-bit space.
        do_reset();
        lat_min = 1; lat_max = 1;
        step(1'b1, 32'hFFFF_FFFC);
        repeat (12) step(1'b0, '0);
        check_val("wrap_req0", (hs_log.size() > 1) ? 64'(hs_log[0]) : 64'hDEAD, 64'hFFFF_FFFC);
        check_val("wrap_req1", (hs_log.size() > 1) ? 64'(hs_log[1]) : 64'hDEAD, 64'h0);

        // Random soak: toggling ready, latency 1-5, random decode stalls and redirects.
        do_reset();
        ready_mode = 1; lat_min = 1; lat_max = 5; oready_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3)
                step(1'b1, ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                       : 32'($urandom));
            else step(1'b0, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
